// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the 20-bit datapath.
// The controller takes the master modport; the datapath side takes the slave modport.
interface multicycle_ctrl_if;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 4;

    logic [OPC_W-1:0]   opcode;
    logic               zero;
    logic               mem_ready;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               ext_op;
    logic [2:0]         alu_op;
    logic               retire;
    logic               halted;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output ir_write, pc_write, pc_src, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ext_op, alu_op, retire, halted, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ir_write, pc_write, pc_src, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ext_op, alu_op, retire, halted, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer stepping each instruction through fetch/decode/execute/memory/write-back,
// sharing one memory port, one ALU and the register file across cycles.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned STATE_W = 4;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ANDI = 4'h2;
    localparam logic [3:0] OP_ORI  = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_BNE  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   bad_opcode;

    // Anything outside the fixed opcode map lands in HALT with the sticky flag.
    assign bad_opcode = (bus.opcode[3] == 1'b1) && (bus.opcode != OP_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_DECODE) && bad_opcode) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:                    state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:            state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    default:                 state_d = S_HALT;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_REG;
        bus.ext_op     = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.retire     = 1'b0;
        bus.halted     = 1'b0;
        bus.illegal    = illegal_q;
        bus.state      = STATE_W'(state_q);
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_ONE;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM;
                bus.ext_op    = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_ANDI: bus.alu_op = ALU_AND;
                    OP_ORI:  bus.alu_op = ALU_OR;
                    default: bus.ext_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_op    = 1'b1;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                bus.retire    = bus.mem_ready;
            end
            S_WB_R: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                bus.retire    = 1'b1;
            end
            S_WB_I: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.retire     = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_src    = 1'b1;
                bus.retire    = 1'b1;
                bus.pc_write  = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
        // A reset cycle abandons whatever was in flight.
        if (reset) begin
            bus.ir_write  = 1'b0;
            bus.pc_write  = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
            bus.retire    = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level step model checked every cycle,
// plus directed instruction runs with hand-computed cycle counts and strobe tallies.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_op;
        logic       retire;
        logic       halted;
        logic       illegal;
        logic [3:0] state;
    } cw_t;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: position within the current instruction's step list, plus halt/illegal flags.
    int m_idx  = 0;
    bit m_halt = 1'b0;
    bit m_ill  = 1'b0;

    function automatic cw_t cur_word();
        cw_t w;
        w = '{bus.ir_write, bus.pc_write, bus.pc_src, bus.iord, bus.mem_read,
              bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
              bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_op,
              bus.retire, bus.halted, bus.illegal, bus.state};
        return w;
    endfunction

    function automatic int instr_len(logic [3:0] opc);
        case (opc)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h5: return 4;
            4'h4:                         return 5;
            default:                      return 3;
        endcase
    endfunction

    // Step lists: R {0,1,2,7}, I {0,1,3,8}, LW {0,1,4,5,9}, SW {0,1,4,6}, BR {0,1,10}.
    function automatic int phase_of(logic [3:0] opc, int idx, bit halt);
        if (halt) return 11;
        if (idx == 0) return 0;
        if (idx == 1) return 1;
        case (opc)
            4'h0:             return (idx == 2) ? 2 : 7;
            4'h1, 4'h2, 4'h3: return (idx == 2) ? 3 : 8;
            4'h4:             return (idx == 2) ? 4 : ((idx == 3) ? 5 : 9);
            4'h5:             return (idx == 2) ? 4 : 6;
            default:          return 10;
        endcase
    endfunction

    function automatic cw_t model(int ph, logic [3:0] opc, logic z, logic mr, logic rst, logic ill);
        cw_t w;
        w = '0;
        w.state   = 4'(ph);
        w.illegal = ill;
        case (ph)
            0: begin w.mem_read = 1; w.alu_src_b = 2'b01; w.ir_write = mr; w.pc_write = mr; end
            1: begin w.alu_src_b = 2'b10; w.ext_op = 1; end
            2: begin w.alu_src_a = 1; w.alu_op = 3'b010; end
            3: begin
                w.alu_src_a = 1; w.alu_src_b = 2'b10;
                if (opc == 4'h1) w.ext_op = 1;
                if (opc == 4'h2) w.alu_op = 3'b011;
                if (opc == 4'h3) w.alu_op = 3'b100;
            end
            4: begin w.alu_src_a = 1; w.alu_src_b = 2'b10; w.ext_op = 1; end
            5: begin w.mem_read = 1; w.iord = 1; end
            6: begin w.mem_write = 1; w.iord = 1; w.retire = mr; end
            7: begin w.reg_write = 1; w.reg_dst = 1; w.retire = 1; end
            8: begin w.reg_write = 1; w.retire = 1; end
            9: begin w.reg_write = 1; w.mem_to_reg = 1; w.retire = 1; end
            10: begin
                w.alu_src_a = 1; w.alu_op = 3'b001; w.pc_src = 1; w.retire = 1;
                w.pc_write = (opc == 4'h6) ? z : !z;
            end
            default: w.halted = 1;
        endcase
        if (rst) begin
            w.ir_write = 0; w.pc_write = 0; w.mem_read = 0;
            w.mem_write = 0; w.reg_write = 0; w.retire = 0;
        end
        return w;
    endfunction

    // Per-cycle comparison against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            int  ph;
            bit  adv;
            cw_t exp_w;
            cw_t act_w;
            ph    = phase_of(bus.opcode, m_idx, m_halt);
            exp_w = model(ph, bus.opcode, bus.zero, bus.mem_ready, reset, m_ill);
            act_w = cur_word();
            checks++;
            if (act_w !== exp_w) begin
                errors++;
                $display("FAIL ctrl_word t=%0t phase=%0d actual=%h required=%h", $time, ph, act_w, exp_w);
            end
            if (reset) begin
                m_idx = 0; m_halt = 0; m_ill = 0;
            end else if (!m_halt) begin
                adv = !(ph == 0 || ph == 5 || ph == 6) || bus.mem_ready;
                if (ph == 1 && bus.opcode[3]) begin
                    m_halt = 1;
                    if (bus.opcode != 4'hF) m_ill = 1;
                end else if (adv) begin
                    m_idx = (m_idx == instr_len(bus.opcode) - 1) ? 0 : m_idx + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Runs one instruction from FETCH; mem_ready is low for cycles [st_at, st_at+st_len).
    task automatic run(input logic [3:0] opc, input logic z, input int st_at, input int st_len,
                       input int max_c, input int probe, output int cyc, output int nret,
                       output int npcb, output int nmri, output int nir, output cw_t pw);
        bit done;
        cw_t w;
        done = 0; cyc = -1; nret = 0; npcb = 0; nmri = 0; nir = 0; pw = '0;
        bus.opcode = opc;
        bus.zero   = z;
        for (int c = 0; c < max_c; c++) begin
            bus.mem_ready = !(c >= st_at && c < st_at + st_len);
            @(negedge clk);
            w = cur_word();
            if (c == probe) pw = w;
            if (w.retire) nret++;
            if (w.pc_write && w.pc_src) npcb++;
            if (w.mem_read && w.iord) nmri++;
            if (w.ir_write) nir++;
            if (w.retire) begin cyc = c + 1; done = 1; end
            else if (w.halted) begin cyc = c; done = 1; end
            @(posedge clk); #1;
            if (done) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int  cyc, nret, npcb, nmri, nir;
        cw_t pw;
        bus.opcode = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_mem_read", int'(bus.mem_read), 0);
        chk("reset_illegal", int'(bus.illegal), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run(4'h0, 1'b0, 99, 0, 20, 3, cyc, nret, npcb, nmri, nir, pw);
        chk("r_cycles", cyc, 4);
        chk("r_retires", nret, 1);
        chk("r_ir_writes", nir, 1);
        chk("r_wb_state", int'(pw.state), 7);
        chk("r_wb_regdst", int'({pw.reg_write, pw.reg_dst}), 3);

        run(4'h4, 1'b0, 3, 3, 20, 7, cyc, nret, npcb, nmri, nir, pw);
        chk("lw_cycles", cyc, 8);
        chk("lw_mem_rd_hold", nmri, 4);
        chk("lw_wb_word", int'({pw.state, pw.reg_write, pw.mem_to_reg}), 'b1001_1_1);

        run(4'h6, 1'b1, 99, 0, 20, 2, cyc, nret, npcb, nmri, nir, pw);
        chk("beq_taken_cycles", cyc, 3);
        chk("beq_taken_pcw", npcb, 1);
        run(4'h6, 1'b0, 99, 0, 20, 2, cyc, nret, npcb, nmri, nir, pw);
        chk("beq_nt_cycles", cyc, 3);
        chk("beq_nt_pcw", npcb, 0);
        chk("beq_nt_retires", nret, 1);
        run(4'h7, 1'b0, 99, 0, 20, 2, cyc, nret, npcb, nmri, nir, pw);
        chk("bne_taken_pcw", npcb, 1);

        run(4'h2, 1'b0, 99, 0, 20, 2, cyc, nret, npcb, nmri, nir, pw);
        chk("andi_exec", int'({pw.ext_op, pw.alu_op, pw.alu_src_b}), 'b0_011_10);
        run(4'h1, 1'b0, 99, 0, 20, 2, cyc, nret, npcb, nmri, nir, pw);
        chk("addi_exec", int'({pw.ext_op, pw.alu_op, pw.alu_src_b}), 'b1_000_10);
        run(4'h3, 1'b0, 99, 0, 20, 2, cyc, nret, npcb, nmri, nir, pw);
        chk("ori_exec", int'({pw.ext_op, pw.alu_op, pw.alu_src_b}), 'b0_100_10);
        chk("ori_cycles", cyc, 4);

        run(4'h5, 1'b0, 99, 0, 20, 3, cyc, nret, npcb, nmri, nir, pw);
        chk("sw_cycles", cyc, 4);
        chk("sw_retire_word", int'({pw.mem_write, pw.iord, pw.retire}), 'b111);
        run(4'h5, 1'b0, 0, 2, 20, 0, cyc, nret, npcb, nmri, nir, pw);
        chk("sw_fetch_stall_cycles", cyc, 6);

        run(4'h9, 1'b0, 99, 0, 10, 1, cyc, nret, npcb, nmri, nir, pw);
        chk("illegal_reach_cycles", cyc, 2);
        chk("illegal_retires", nret, 0);
        for (int i = 0; i < 10; i++) begin
            bus.opcode    = 4'($urandom_range(0, 15));
            bus.zero      = 1'($urandom_range(0, 1));
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_strobes", int'({bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write,
                                      bus.reg_write, bus.retire, bus.halted, bus.illegal}), 'b000000_11);
            @(posedge clk); #1;
        end
        do_reset();

        run(4'hF, 1'b0, 99, 0, 10, 0, cyc, nret, npcb, nmri, nir, pw);
        chk("restart_fetch", int'({pw.state, pw.illegal}), 0);
        chk("halt_reach_cycles", cyc, 2);
        @(negedge clk);
        chk("halt_flags", int'({bus.halted, bus.illegal}), 'b10);
        @(posedge clk); #1;
        do_reset();

        run(4'h5, 1'b0, 3, 50, 6, 5, cyc, nret, npcb, nmri, nir, pw);
        chk("sw_wait_no_retire", cyc, -1);
        chk("sw_wait_state", int'(pw.state), 6);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_memwr", int'({bus.mem_write, bus.retire}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_after_state", int'({bus.state, bus.retire}), 0);
        @(posedge clk); #1;

        run(4'h0, 1'b0, 99, 0, 20, 3, cyc, nret, npcb, nmri, nir, pw);
        chk("r_after_reset_cycles", cyc, 4);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the 20-bit processor datapath. It replaces the single-cycle decode path, so one shared memory port, one ALU and the 16-entry register file are reused across the stages of each instruction. Each instruction steps through fetch, decode, execute, memory and write-back states, and the controller drives every datapath strobe and mux select. Memory accesses use a ready handshake, so slow memory stretches any access state.

## Interface
Parameters: none. Opcode map is fixed: 0x0 R-type, 0x1 ADDI, 0x2 ANDI, 0x3 ORI, 0x4 LW, 0x5 SW, 0x6 BEQ, 0x7 BNE, 0xF HALT, all others illegal.
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  4  instruction[19:16] from instruction register
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes the current read/write this cycle
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  0 = ALU result (PC+1), 1 = ALUOut register (branch target)
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read / mem_write  out  1 each  memory strobes
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = instruction[11:8], 1 = instruction[7:4]
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = memory data register
- alu_src_a  out  1  0 = PC, 1 = reg1
- alu_src_b  out  2  00 = reg2, 01 = constant 1, 10 = extended immediate
- ext_op  out  1  1 = sign-extend imm[7:0], 0 = zero-extend
- alu_op  out  3  000 ADD, 001 SUB, 010 use funct[3:0], 011 AND, 100 OR
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- halted  out  1  in HALT state
- illegal  out  1  sticky, set on entering HALT via an undefined opcode
- state  out  4  current state encoding, for debug

## Operation
- Moore FSM. Outputs decode from the state register, except that the strobes gated by mem_ready or zero are noted per state. Any output not listed for a state is 0.
- FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - ir_write and pc_write (pc_src=0) assert only when mem_ready=1, and the FSM then goes to DECODE.
  - Otherwise it stays in FETCH.
- DECODE (1): precompute branch target into ALUOut: alu_src_a=0, alu_src_b=10, ext_op=1, alu_op=ADD. Next state by opcode:
  - 0x0 → EXEC_R
  - 0x1/0x2/0x3 → EXEC_I
  - 0x4/0x5 → MEM_ADDR
  - 0x6/0x7 → BRANCH
  - 0xF → HALT
  - other → HALT with illegal set
- EXEC_R (2): alu_src_a=1, alu_src_b=00, alu_op=010. Next WB_R.
- EXEC_I (3): alu_src_a=1, alu_src_b=10. Next WB_I.
  - ADDI: ext_op=1, ADD.
  - ANDI: ext_op=0, AND.
  - ORI: ext_op=0, OR.
- MEM_ADDR (4): alu_src_a=1, alu_src_b=10, ext_op=1, ADD. Next MEM_RD for LW, MEM_WR for SW.
- MEM_RD (5): mem_read=1, iord=1. Waits on mem_ready, then WB_MEM.
- MEM_WR (6): mem_write=1, iord=1. Waits on mem_ready, then FETCH with retire=1 in the mem_ready cycle.
- WB_R (7): reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next FETCH.
- WB_I (8): reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next FETCH.
- WB_MEM (9): reg_write=1, reg_dst=0, mem_to_reg=1, retire=1. Next FETCH.
- BRANCH (10): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=1, retire=1. Next FETCH.
  - BEQ: pc_write = zero.
  - BNE: pc_write = !zero.
- HALT (11): halted=1, all strobes 0. Stays in HALT until reset, ignoring all inputs.
- illegal stays set until reset; HALT via 0xF leaves illegal=0.

## Timing
- Reset: on a clk edge with reset=1, state←FETCH and illegal←0.
  - While reset=1, all write/read strobes (ir_write, pc_write, mem_read, mem_write, reg_write) and retire are forced to 0.
  - The first fetch read is issued in the cycle after reset deasserts.
  - Reset mid-instruction (including during a memory wait) abandons the instruction; no further strobes are issued for it.
- Cycles per instruction with mem_ready held at 1:
  - R-type / I-type: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE: 3
  - HALT: 2 to reach HALT
- Each cycle mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
  - Strobes mem_read/mem_write and iord stay stable for the whole wait.
  - There is no timeout.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- retire: exactly one pulse per completed instruction, never for HALT or illegal opcodes.

## Test plan
- Reset, then mem_ready=1 and opcode=0x0 → states 0,1,2,7,0. ir_write and pc_write high in cycle 0 only, reg_write=1 with reg_dst=1 in cycle 3, retire=1 in cycle 3.
- LW (0x4) with mem_ready=0 for 3 cycles in MEM_RD → mem_read=1 and iord=1 held for 4 cycles. Then WB_MEM with mem_to_reg=1 and reg_write=1. Total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0 → pc_write=1 with pc_src=1 in BRANCH only for the first. Both take 3 cycles and each pulses retire once.
- ANDI (0x2) → EXEC_I shows ext_op=0, alu_op=011, alu_src_b=10. ADDI (0x1) shows ext_op=1, alu_op=000.
- opcode=0x9 → HALT with illegal=1 and halted=1. Strobes stay 0 for 10 cycles regardless of inputs. Reset clears illegal and restarts FETCH.
- Assert reset during a MEM_WR wait → mem_write=0 in the reset cycle, state=FETCH afterward, no retire pulse.
